// File: rtl/fp_mul_pkg.sv
// Shared widths and payload types for the floating-point multiply post-processing path.
package fp_mul_pkg;

    localparam int unsigned N    = 6;
    localparam int unsigned EW   = 8;
    localparam int unsigned BIAS = 127;
    localparam int unsigned FW   = N - 1;
    localparam int unsigned RW   = 1 + EW + FW;
    localparam int unsigned XW   = EW + 2;
    localparam int unsigned PW   = 2 * N;

    // Biased exponent that encodes infinity, held at the signed internal width
    localparam logic signed [XW-1:0] EXP_INF = XW'((2 ** EW) - 1);

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [FW-1:0] frac;
    } fp_word_t;

    typedef struct packed {
        logic                   sign;
        logic                   zero;
        logic signed [XW-1:0]   exp;
        logic [N-1:0]           mant;
        logic                   guard;
        logic                   sticky;
    } s1_payload_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of an N-bit mantissa, renormalising on carry-out.
module fp_round_rne
    import fp_mul_pkg::*;
(
    input  logic [N-1:0] mant_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    output logic [N-1:0] mant_o_c,
    output logic         exp_inc_o_c
);

    logic         round_up;
    logic [N:0]   sum;

    always_comb begin
        round_up    = guard_i & (sticky_i | mant_i[0]);
        sum         = {1'b0, mant_i} + (N+1)'(round_up);
        exp_inc_o_c = sum[N];
        // Carry only happens from all-ones, so the shifted sum is exactly 1.000..0
        mant_o_c    = sum[N] ? sum[N:1] : sum[N-1:0];
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Post-multiply stage: normalise, round to nearest-even, range-check and pack, over a 2-deep pipeline.
module fp_mul_norm_round
    import fp_mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PW-1:0]   in_prod,
    input  logic [XW-1:0]   in_exp,
    input  logic            in_sign,
    input  logic            in_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_result,
    output logic            out_ovf,
    output logic            out_unf
);

    s1_payload_t          s1_q, s1_d;
    logic                 s1_valid_q;
    logic                 s2_valid_q;
    fp_word_t             res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 s1_en_c;
    logic                 s2_en_c;
    logic signed [XW-1:0] in_exp_s;
    logic [N-1:0]         mant_rnd;
    logic                 exp_inc;
    logic signed [XW-1:0] exp_rnd;
    logic                 unused_hidden;

    assign s2_en_c  = !s2_valid_q || out_ready;
    assign s1_en_c  = !s1_valid_q || s2_en_c;
    assign in_ready = s1_en_c;
    assign in_exp_s = $signed(in_exp);

    // Stage 1: align the product so the hidden bit sits at mant[N-1]
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.zero = in_zero;
        if (in_prod[PW-1]) begin
            s1_d.mant   = in_prod[PW-1:N];
            s1_d.guard  = in_prod[N-1];
            s1_d.sticky = |in_prod[N-2:0];
            s1_d.exp    = in_exp_s + $signed(XW'(1));
        end else begin
            s1_d.mant   = in_prod[PW-2:N-1];
            s1_d.guard  = in_prod[N-2];
            s1_d.sticky = |in_prod[N-3:0];
            s1_d.exp    = in_exp_s;
        end
    end

    fp_round_rne u_round (
        .mant_i      (s1_q.mant),
        .guard_i     (s1_q.guard),
        .sticky_i    (s1_q.sticky),
        .mant_o_c    (mant_rnd),
        .exp_inc_o_c (exp_inc)
    );

    assign exp_rnd       = s1_q.exp + $signed({{(XW-1){1'b0}}, exp_inc});
    assign unused_hidden = mant_rnd[N-1];

    // Stage 2: range checks and packing; zero wins over both range flags
    always_comb begin
        res_d      = '0;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        res_d.sign = s1_q.sign;
        if (s1_q.zero) begin
            res_d.exp  = '0;
        end else if (exp_rnd >= EXP_INF) begin
            res_d.exp  = '1;
            ovf_d      = 1'b1;
        end else if (exp_rnd <= $signed(XW'(0))) begin
            res_d.exp  = '0;
            unf_d      = 1'b1;
        end else begin
            res_d.exp  = exp_rnd[EW-1:0];
            res_d.frac = mant_rnd[FW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (s1_en_c) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_en_c) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                    ovf_q <= ovf_d;
                    unf_q <= unf_d;
                end
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_valid_q ? res_q : '0;
    assign out_ovf    = s2_valid_q & ovf_q;
    assign out_unf    = s2_valid_q & unf_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round: single beats, range limits, backpressure and mid-stream reset.
module tb_fp_mul_norm_round;
    import fp_mul_pkg::*;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_prod;
    logic [XW-1:0]   in_exp;
    logic            in_sign;
    logic            in_zero;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   out_result;
    logic            out_ovf;
    logic            out_unf;

    fp_mul_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] prod;
        int          e;
        logic        s;
        logic        z;
        logic [13:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] p, input int e, input logic s, input logic z,
                                input logic [13:0] r, input logic o, input logic u);
        vec_t v;
        v.prod = p; v.e = e; v.s = s; v.z = z; v.res = r; v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_prod  = v.prod;
        in_exp   = XW'(v.e);
        in_sign  = v.s;
        in_zero  = v.z;
    endtask

    task automatic run_one(input int i);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(vecs[i]);
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", i), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_early_valid", i), out_valid, 0);
        @(negedge clk);
        chk($sformatf("v%0d_valid", i), out_valid, 1);
        chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
        chk($sformatf("v%0d_ovf", i), out_ovf, vecs[i].ovf);
        chk($sformatf("v%0d_unf", i), out_unf, vecs[i].unf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          occ;
        int          sent;
        int          got;
        logic        acc;
        logic        dlv;
        logic        stalled;
        logic [13:0] held;

        vecs[0]  = mk(12'h400, 127, 0, 0, 14'h0FE0, 0, 0);
        vecs[1]  = mk(12'hF81, 127, 0, 0, 14'h101E, 0, 0);
        vecs[2]  = mk(12'h690, 127, 0, 0, 14'h0FF4, 0, 0);
        vecs[3]  = mk(12'h6F0, 127, 0, 0, 14'h0FF8, 0, 0);
        vecs[4]  = mk(12'h7F8, 127, 0, 0, 14'h1000, 0, 0);
        vecs[5]  = mk(12'hF81, 254, 1, 0, 14'h3FE0, 1, 0);
        vecs[6]  = mk(12'h400,   0, 1, 0, 14'h2000, 0, 1);
        vecs[7]  = mk(12'hF81, 254, 1, 1, 14'h2000, 0, 0);
        vecs[8]  = mk(12'hF81, 253, 0, 0, 14'h1FDE, 0, 0);
        vecs[9]  = mk(12'h400,   1, 0, 0, 14'h0020, 0, 0);
        vecs[10] = mk(12'h7F8, 254, 0, 0, 14'h1FE0, 1, 0);
        vecs[11] = mk(12'h400,  -5, 0, 0, 14'h0000, 0, 1);
        vecs[12] = mk(12'h7F8,  -1, 0, 0, 14'h0000, 0, 1);
        vecs[13] = mk(12'h800,  -1, 1, 0, 14'h2000, 0, 1);
        vecs[14] = mk(12'h800,   0, 0, 0, 14'h0020, 0, 0);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        in_zero   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", {out_ovf, out_unf}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < NV; i++) begin
            run_one(i);
        end

        // Backpressure: consumer stalls for the first 4 cycles of a 5-beat stream
        occ = 0; sent = 0; got = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 4);
            if (sent < 5) drive(vecs[sent]);
            else          in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, (occ < 2) || out_ready);
            if (cyc == 3) chk("bp_held_two", sent, 2);
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (out_valid && !out_ready) begin
                if (stalled) chk($sformatf("bp_stable_c%0d", cyc), out_result, held);
                held    = out_result;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (dlv) begin
                if (got < 5) chk($sformatf("bp_order_%0d", got), out_result, vecs[got].res);
                got++;
            end
            if (acc) sent++;
            occ = occ + int'(acc) - int'(dlv);
        end
        chk("bp_delivered", got, 5);

        // Reset asserted while beats are in flight
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(vecs[k]);
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_result", out_result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        chk("mid_rst_no_output", got, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
